// File: rtl/prog_loader.sv
// Program-memory front end for the core's instruction fetch.
// Words stream in over valid/ready and are written into program memory.
// The core is held idle until a complete program has been loaded.
// Fetch reads are combinational. Any address at or beyond the loaded
// length reads as zero, so a reset load (length 0) hides all old contents.
module prog_loader #(
  parameter int D = 12,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  input  logic [D-1:0] rd_addr,
  output logic [W-1:0] rd_data,
  output logic         core_run,
  input  logic         core_done,
  output logic [D:0]   load_count,
  output logic         busy,
  output logic         error
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    HALT,
    ERR
  } state_e;

  localparam logic [D-1:0] PTR_ONE = {{(D-1){1'b0}}, 1'b1};
  localparam logic [D-1:0] PTR_MAX = {D{1'b1}};
  localparam logic [D:0]   CNT_ONE = {{D{1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [D-1:0]   wrPtr_q, wrPtr_d;
  logic [D:0]     loadCount_q, loadCount_d;
  logic           wrEn;
  logic [D-1:0]   wrAddr;
  logic [W-1:0]   mem_q [0:(1<<D)-1];

  // State, write pointer and load length; memory contents survive reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wrPtr_q     <= '0;
      loadCount_q <= '0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      loadCount_q <= loadCount_d;
    end
  end

  // Next-state logic, beat acceptance and state-decoded outputs
  always_comb begin
    state_d     = state_q;
    wrPtr_d     = wrPtr_q;
    loadCount_d = loadCount_q;
    wrEn        = 1'b0;
    wrAddr      = wrPtr_q;
    in_ready    = 1'b0;
    busy        = 1'b0;
    core_run    = 1'b0;
    error       = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        in_ready = 1'b1;
        busy     = (state_q == LOAD);
        if (in_valid) begin
          wrEn        = 1'b1;
          loadCount_d = loadCount_q + CNT_ONE;
          // The pointer saturates at the top so it can never wrap onto word 0
          wrPtr_d     = (wrPtr_q == PTR_MAX) ? wrPtr_q : wrPtr_q + PTR_ONE;
          if (in_last) begin
            state_d = RUN;
          end else if (wrPtr_q == PTR_MAX) begin
            state_d = ERR;
          end else begin
            state_d = LOAD;
          end
        end
      end
      RUN: begin
        core_run = 1'b1;
        if (core_done) begin
          state_d = HALT;
        end
      end
      HALT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // A new program always restarts at address 0
          wrEn        = 1'b1;
          wrAddr      = '0;
          wrPtr_d     = PTR_ONE;
          loadCount_d = CNT_ONE;
          state_d     = in_last ? RUN : LOAD;
        end
      end
      ERR: begin
        error = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Program memory write port
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem_q[wrAddr] <= in_data;
    end
  end

  assign load_count = loadCount_q;
  assign rd_data    = ({1'b0, rd_addr} < loadCount_q) ? mem_q[rd_addr] : '0;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader built with a small memory (D=3) so the overflow
// path is reachable. The reference model tracks the loaded program as a
// plain array plus a length and a few flags describing what the core may do.
module tb_prog_loader;

  localparam int D     = 3;
  localparam int W     = 9;
  localparam int DEPTH = 1 << D;

  logic         clk;
  logic         reset;
  logic         inValid;
  logic [W-1:0] inData;
  logic         inLast;
  logic         inReady;
  logic [D-1:0] rdAddr;
  logic [W-1:0] rdData;
  logic         coreRun;
  logic         coreDone;
  logic [D:0]   loadCount;
  logic         busy;
  logic         error;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  int   modelMem [DEPTH];
  int   modelLen;
  bit   modelRunning;
  bit   modelFault;
  bit   modelLoading;

  prog_loader #(.D(D), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (inValid),
    .in_data    (inData),
    .in_last    (inLast),
    .in_ready   (inReady),
    .rd_addr    (rdAddr),
    .rd_data    (rdData),
    .core_run   (coreRun),
    .core_done  (coreDone),
    .load_count (loadCount),
    .busy       (busy),
    .error      (error)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int modelRead(input int addr);
    return (addr < modelLen) ? modelMem[addr] : 0;
  endfunction

  task automatic modelReset();
    modelLen     = 0;
    modelRunning = 1'b0;
    modelFault   = 1'b0;
    modelLoading = 1'b0;
  endtask

  // One rising edge as the spec describes it: loads only while the core is
  // not running and no overflow happened; done only matters while running
  task automatic modelEdge(input bit v, input int data, input bit last, input bit done);
    if (modelRunning) begin
      if (done) modelRunning = 1'b0;
    end else if (!modelFault && v) begin
      if (!modelLoading) modelLen = 0;
      modelMem[modelLen] = data;
      modelLen++;
      if (last) begin
        modelRunning = 1'b1;
        modelLoading = 1'b0;
      end else if (modelLen == DEPTH) begin
        modelFault   = 1'b1;
        modelLoading = 1'b0;
      end else begin
        modelLoading = 1'b1;
      end
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".in_ready"},   32'(inReady),   32'(!modelRunning && !modelFault));
    checkOutput({tag, ".core_run"},   32'(coreRun),   32'(modelRunning));
    checkOutput({tag, ".busy"},       32'(busy),      32'(modelLoading));
    checkOutput({tag, ".error"},      32'(error),     32'(modelFault));
    checkOutput({tag, ".load_count"}, 32'(loadCount), 32'(modelLen));
  endtask

  task automatic readCheck(input string tag, input int addr, input int expected);
    rdAddr = D'(addr);
    #1;
    checkOutput(tag, 32'(rdData), 32'(expected));
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model
  task automatic applyStimulus(input bit v, input int data, input bit last,
                               input bit done, input string tag);
    int a;
    inValid  = v;
    inData   = W'(data);
    inLast   = last;
    coreDone = done;
    @(posedge clk);
    modelEdge(v, data, last, done);
    #1;
    inValid  = 1'b0;
    coreDone = 1'b0;
    checkState(tag);
    a = $urandom_range(DEPTH - 1);
    readCheck({tag, ".rd_rand"}, a, modelRead(a));
  endtask

  task automatic applyReset();
    reset = 1'b0;
    modelReset();
    #3;
    reset = 1'b1;
  endtask

  initial begin
    int v, last, done;
    reset    = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    inLast   = 1'b0;
    coreDone = 1'b0;
    rdAddr   = '0;
    modelReset();
    #2;
    checkState("reset");
    readCheck("reset.rd0", 0, 0);
    #10 reset = 1'b1;

    // Three-word program
    $display("[TB] three-word load");
    applyStimulus(1, 'h0A5, 0, 0, "load3.w0");
    applyStimulus(1, 'h1FF, 0, 0, "load3.w1");
    applyStimulus(1, 'h040, 1, 0, "load3.w2");
    checkOutput("load3.count", 32'(loadCount), 32'd3);
    checkOutput("load3.run",   32'(coreRun),   32'd1);
    readCheck("load3.rd1", 1, 'h1FF);
    readCheck("load3.rd3", 3, 'h000);

    // Stream data is ignored while running
    applyStimulus(1, 'h123, 0, 0, "run.ignore");
    checkOutput("run.ready", 32'(inReady), 32'd0);
    readCheck("run.rd0", 0, 'h0A5);
    checkOutput("run.count", 32'(loadCount), 32'd3);

    // Done halts the core; a single-word reload restarts it
    applyStimulus(0, 0, 0, 1, "halt");
    checkOutput("halt.run", 32'(coreRun), 32'd0);
    applyStimulus(1, 'h077, 1, 0, "reload");
    checkOutput("reload.count", 32'(loadCount), 32'd1);
    readCheck("reload.rd0", 0, 'h077);
    readCheck("reload.rd1", 1, 'h000);
    checkOutput("reload.run", 32'(coreRun), 32'd1);

    // Overflow: fill all of memory without a last marker
    $display("[TB] overflow");
    @(negedge clk);
    applyReset();
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1, i, 0, 0, "ovf.fill");
    checkOutput("ovf.error", 32'(error),     32'd1);
    checkOutput("ovf.count", 32'(loadCount), 32'(DEPTH));
    readCheck("ovf.rd7", DEPTH - 1, DEPTH);
    applyStimulus(1, 'h1AA, 1, 0, "ovf.extra");
    applyStimulus(0, 0, 0, 1, "ovf.done");
    checkOutput("ovf.sticky", 32'(error), 32'd1);

    // Asynchronous reset in the middle of a load
    $display("[TB] reset mid-load");
    @(negedge clk);
    applyReset();
    applyStimulus(1, 'h101, 0, 0, "midrst.w0");
    applyStimulus(1, 'h102, 0, 0, "midrst.w1");
    #1 reset = 1'b0;
    modelReset();
    #1;
    checkState("midrst.async");
    for (int a = 0; a < DEPTH; a++) readCheck("midrst.rdzero", a, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1, 'h0F0 + i, i == 3, 0, "midrst.fresh");
    for (int a = 0; a < DEPTH; a++) readCheck("midrst.rdback", a, modelRead(a));

    // Single-word program straight from idle
    $display("[TB] single-word load");
    @(negedge clk);
    applyReset();
    applyStimulus(1, 'h155, 1, 0, "single");
    checkOutput("single.busy", 32'(busy),    32'd0);
    checkOutput("single.run",  32'(coreRun), 32'd1);

    // Randomized traffic
    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      if (modelFault) begin
        @(negedge clk);
        applyReset();
      end
      v    = ($urandom_range(3) != 0);
      last = ($urandom_range(4) == 0);
      done = ($urandom_range(5) == 0);
      applyStimulus(v[0], int'($urandom_range((1 << W) - 1)), last[0], done[0], "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Program-memory front end that sits directly upstream of the core's instruction fetch and replaces the fixed instruction ROM.
- Accepts 9-bit machine-code words over a valid/ready stream and writes them into an internal program memory.
- Serves combinational reads to the core at `prog_ctr`.
- Holds the core idle (`core_run`=0) until a complete program is loaded, then releases it; returns to a reloadable state when the core signals done.

Parameters:
- D, 12, program counter / program memory address width (depth 2^D).
- W, 9, machine-code word width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  load-stream word valid.
- in_data  input  W  load-stream machine-code word.
- in_last  input  1  marks the final word of a program; qualified by in_valid.
- in_ready  output  1  loader can accept a word this cycle.
- rd_addr  input  D  fetch address, driven from the core's prog_ctr.
- rd_data  output  W  machine code to the core's decode.
- core_run  output  1  1 = core may execute; 0 = core held at PC 0 by the integrator.
- core_done  input  1  core's done indication (PC all-ones).
- load_count  output  D+1  number of words accepted in the current/last load.
- busy  output  1  high in LOAD.
- error  output  1  overflow error flag, sticky until reset.

Behaviour:
- Clocking and reset
  - Single clock domain.
  - Reset low asynchronously forces: state=IDLE, wr_ptr=0, load_count=0, core_run=0, busy=0, error=0.
  - Program memory contents are not cleared by reset.
- Beat acceptance
  - A beat is accepted on a rising edge with in_valid && in_ready.
  - On acceptance: mem[wr_ptr] <= in_data, wr_ptr increments, load_count increments.
- States
  - IDLE: in_ready=1.
    - Accepted beat with in_last=0 -> LOAD.
    - Accepted beat with in_last=1 -> RUN.
  - LOAD: in_ready=1, busy=1.
    - Accepted beat with in_last=1 -> RUN.
    - Accepted beat at wr_ptr=2^D-1 with in_last=0 -> ERR. That word is still written; load_count = 2^D.
  - RUN: in_ready=0, core_run=1. Entry is one cycle after the last beat's edge (registered output).
    - core_done=1 sampled on an edge -> HALT; core_run=0 from the next cycle.
    - in_valid is ignored in RUN.
  - HALT: in_ready=1, core_run=0.
    - An accepted beat starts a new load: it is written at address 0, wr_ptr becomes 1, load_count becomes 1. Next state is LOAD, or RUN if in_last=1.
  - ERR: in_ready=0, core_run=0, error=1. Exits only via reset.
- core_done is only acted on in RUN; it is ignored in all other states.
- Read path
  - rd_data is combinational.
  - rd_data = mem[rd_addr] when rd_addr < load_count; otherwise W'b0.
  - Same-cycle write and read of one address returns the old contents until the edge.
- Width rules
  - load_count is D+1 bits so that a full memory (2^D) is representable.
  - wr_ptr is D bits and never wraps; overflow goes to ERR instead.
- Reset mid-load: all progress is discarded. load_count=0, so every rd_data reads 0 until a new load.

Test Plan:
- Load 3 words 0x0A5, 0x1FF, 0x040 (last on 3rd), in_valid held high:
  - in_ready=1 for 3 cycles, load_count=3.
  - core_run rises one cycle after the 3rd edge.
  - rd_addr=1 -> rd_data=0x1FF; rd_addr=3 -> 0x000.
- In RUN, assert in_valid with 0x123: in_ready=0, mem[0] unchanged, load_count stays 3.
- In RUN, pulse core_done for one cycle: core_run=0 the next cycle.
  - Then load 1 word 0x077 with in_last=1: load_count=1, rd_addr=0 -> 0x077, rd_addr=1 -> 0x000, core_run=1 again.
- Bench with D=3: stream 8 words 0x001..0x008, in_last never set:
  - ERR after the 8th edge; error=1, in_ready=0, load_count=8, core_run stays 0.
  - A 9th in_valid is not accepted; only reset clears error.
- Assert reset low mid-LOAD after 2 of 4 words, asynchronously between edges:
  - core_run/busy/load_count drop immediately; rd_data=0 at every address.
  - After release, a fresh 4-word load behaves normally.
- Single-word program in IDLE (in_last=1 on the first beat): skips LOAD, busy never asserts, core_run=1 the next cycle.
